// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package if_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_e;

  localparam logic [31:0] PC_INC        = 32'd4;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } qent_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Circular prefetch queue holding {pc, instr} entries.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  qent_t                   din,
  output qent_t                   dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  qent_t         mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= din;
  end

  assign dout  = mem[head];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: PC, halt/redirect FSM, prefetch queue.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pc_q;
  logic        fault_q;
  logic [31:0] cnt_q;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        misaligned;
  logic        halt_push;
  qent_t       head;
  qent_t       din;
  logic [$clog2(DEPTH):0] unused_qcount;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign pop        = out_valid && out_ready;
  assign push       = (state_q == FETCH) && !redirect_valid
                      && (!full || pop);
  assign halt_push  = push && (imem_rdata == HALT_WORD);
  assign din        = '{pc: pc_q, instr: imem_rdata};

  if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (unused_qcount)
  );

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      redirect_valid: state_d = misaligned ? HALTED : FETCH;
      halt_push:      state_d = HALTED;
      default:        state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (redirect_valid) begin
        if (misaligned) fault_q <= 1'b1;
        else            pc_q    <= redirect_pc;
      end else if (push) begin
        pc_q <= pc_q + PC_INC;
      end
      if (push) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = !empty;
  assign out_instr   = out_valid ? head.instr : '0;
  assign out_pc      = out_valid ? head.pc : '0;
  assign out_pc4     = out_valid ? head.pc + PC_INC : '0;
  assign halted      = (state_q == HALTED);
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule
